// File: rtl/fetch_queue.sv
// fetch_queue
// Shallow FIFO between the IF stage and decode. Fetch pushes {PC, instruction}
// pairs, and decode pops the oldest pair through a valid/ready handshake. The
// head entry is read combinationally, so the FIFO is first-word-fall-through
// with one cycle of latency from push to visibility. A redirect (kill) squashes
// every queued wrong-path entry.
//
// Ports:
//   CLK         clock; all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   f_valid     fetch presents a valid pair this cycle
//   f_pc        PC of the fetched instruction
//   f_instr     instruction word for f_pc
//   f_ready     queue can accept a pair (feeds the IF stall input)
//   kill        branch/jump redirect; flush all entries
//   d_valid     head entry valid toward decode
//   d_ready     decode accepts the head this cycle
//   d_pc        head PC (0 when d_valid is 0)
//   d_instr     head instruction (NOP when d_valid is 0)
//   d_misalign  head PC had nonzero low bits when it was pushed
//   count       number of occupied entries, 0..DEPTH
module fetch_queue #(
    parameter int          DEPTH = 2,
    parameter logic [31:0] NOP   = 32'h0000_0000
) (
    input  logic                       CLK,
    input  logic                       rst_n,
    input  logic                       f_valid,
    input  logic [31:0]                f_pc,
    input  logic [31:0]                f_instr,
    output logic                       f_ready,
    input  logic                       kill,
    output logic                       d_valid,
    input  logic                       d_ready,
    output logic [31:0]                d_pc,
    output logic [31:0]                d_instr,
    output logic                       d_misalign,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   entryPc_q    [DEPTH];
    logic [31:0]   entryInstr_q [DEPTH];
    logic          entryMis_q   [DEPTH];

    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [CW-1:0] count_q, count_d;

    logic          push;
    logic          pop;

    // f_ready depends only on registered occupancy. This keeps the IF stall
    // input free of any combinational path from decode or from the redirect.
    // d_valid is masked by kill so that decode cannot consume a wrong-path
    // entry in the same cycle the redirect arrives.
    always_comb begin
        f_ready = (count_q != CW'(DEPTH));
        d_valid = (count_q != '0) && !kill;
        push    = f_valid && f_ready && !kill;
        pop     = d_valid && d_ready;
    end

    // Next-state pointer and occupancy logic. A kill overrides any push or pop
    // and returns the queue to its empty state. A simultaneous push and pop
    // advances both pointers and leaves the count unchanged. Pointers wrap
    // naturally because DEPTH is a power of two.
    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (kill) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wrPtr_d = wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers. Asserting reset drops every entry at
    // once, without waiting for a clock edge.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Entry storage is not reset. The count register alone decides which
    // entries are meaningful. The misalign flag is captured from the PC at
    // push time so that decode can raise the exception later.
    always_ff @(posedge CLK) begin
        if (push) begin
            entryPc_q[wrPtr_q]    <= f_pc;
            entryInstr_q[wrPtr_q] <= f_instr;
            entryMis_q[wrPtr_q]   <= (f_pc[1:0] != 2'b00);
        end
    end

    // Head-of-queue outputs are read straight from the storage, giving
    // first-word-fall-through behaviour. When there is no valid head, these
    // outputs show safe idle values: PC 0, NOP, and no misalign flag.
    always_comb begin
        d_pc       = d_valid ? entryPc_q[rdPtr_q]    : 32'h0;
        d_instr    = d_valid ? entryInstr_q[rdPtr_q] : NOP;
        d_misalign = d_valid ? entryMis_q[rdPtr_q]   : 1'b0;
        count      = count_q;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
// Self-checking bench for fetch_queue. A scoreboard queue receives the
// expected pair whenever the bench's own occupancy model says a push happens.
// The head of the DUT is compared against the front of the scoreboard, and the
// scoreboard is popped whenever the model says decode consumed an entry.
module tb_fetch_queue;

    localparam int          DEPTH = 2;
    localparam int          CW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } entry_t;

    logic          CLK = 1'b0;
    logic          rst_n;
    logic          f_valid;
    logic [31:0]   f_pc;
    logic [31:0]   f_instr;
    logic          f_ready;
    logic          kill;
    logic          d_valid;
    logic          d_ready;
    logic [31:0]   d_pc;
    logic [31:0]   d_instr;
    logic          d_misalign;
    logic [CW-1:0] count;

    entry_t sb[$];
    int     expCount = 0;
    int     total    = 0;
    int     bad      = 0;

    fetch_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .f_valid    (f_valid),
        .f_pc       (f_pc),
        .f_instr    (f_instr),
        .f_ready    (f_ready),
        .kill       (kill),
        .d_valid    (d_valid),
        .d_ready    (d_ready),
        .d_pc       (d_pc),
        .d_instr    (d_instr),
        .d_misalign (d_misalign),
        .count      (count)
    );

    // 10 ns clock period.
    always #5 CLK = ~CLK;

    // Safety net that stops the run if it stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock edge. The reference model decides, from the current
    // inputs and its own occupancy count, whether a push, pop or flush happens,
    // and updates the scoreboard to match.
    task automatic tick();
        bit     mPush;
        bit     mPop;
        entry_t e;
        mPush = f_valid && (expCount != DEPTH) && !kill;
        mPop  = (expCount != 0) && !kill && d_ready;
        e.pc    = f_pc;
        e.instr = f_instr;
        e.mis   = (f_pc[1:0] != 2'b00);
        @(posedge CLK);
        #1;
        if (kill) begin
            sb.delete();
            expCount = 0;
        end else begin
            if (mPop) begin
                void'(sb.pop_front());
                expCount--;
            end
            if (mPush) begin
                sb.push_back(e);
                expCount++;
            end
        end
    endtask

    // Drive one fetch pair, then advance one clock edge.
    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] instr);
        f_valid = 1'b1;
        f_pc    = pc;
        f_instr = instr;
        tick();
    endtask

    task automatic test_reset();
        #1;
        total++; if (d_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_dvalid: got %b required 0", d_valid); end
        total++; if (d_instr !== NOP) begin bad++; $display("[TB] FAIL reset_dinstr: got %h required %h", d_instr, NOP); end
        total++; if (d_pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_dpc: got %h required 0", d_pc); end
        total++; if (d_misalign !== 1'b0) begin bad++; $display("[TB] FAIL reset_mis: got %b required 0", d_misalign); end
        total++; if (f_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_fready: got %b required 1", f_ready); end
        total++; if (count !== '0) begin bad++; $display("[TB] FAIL reset_count: got %0d required 0", count); end
    endtask

    task automatic test_single();
        d_ready = 1'b0;
        applyStimulus(32'h0, 32'h2008_0005);
        f_valid = 1'b0;
        #1;
        total++; if (d_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_dvalid: got %b required 1", d_valid); end
        total++; if (d_pc !== sb[0].pc) begin bad++; $display("[TB] FAIL single_dpc: got %h required %h", d_pc, sb[0].pc); end
        total++; if (d_instr !== sb[0].instr) begin bad++; $display("[TB] FAIL single_dinstr: got %h required %h", d_instr, sb[0].instr); end
        total++; if (count !== CW'(expCount)) begin bad++; $display("[TB] FAIL single_count: got %0d required %0d", count, expCount); end
        total++; if (f_ready !== 1'b1) begin bad++; $display("[TB] FAIL single_fready: got %b required 1", f_ready); end
        d_ready = 1'b1;
        tick();
        d_ready = 1'b0;
        #1;
        total++; if (d_valid !== 1'b0 || d_instr !== NOP) begin bad++; $display("[TB] FAIL single_drain: got v=%b i=%h required v=0 i=%h", d_valid, d_instr, NOP); end
    endtask

    task automatic test_full();
        d_ready = 1'b0;
        applyStimulus(32'h00, 32'hA000_0000);
        applyStimulus(32'h04, 32'hA000_0004);
        f_pc    = 32'h08;
        f_instr = 32'hA000_0008;
        #1;
        total++; if (count !== CW'(expCount) || f_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_state: got c=%0d r=%b required c=%0d r=0", count, f_ready, expCount); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (count !== CW'(expCount) || f_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_hold: got c=%0d r=%b required c=%0d r=0", count, f_ready, expCount); end
        end
        d_ready = 1'b1;
        tick();
        d_ready = 1'b0;
        #1;
        total++; if (f_ready !== 1'b1 || count !== CW'(expCount)) begin bad++; $display("[TB] FAIL full_afterpop: got c=%0d r=%b required c=%0d r=1", count, f_ready, expCount); end
        total++; if (d_pc !== sb[0].pc) begin bad++; $display("[TB] FAIL full_head04: got %h required %h", d_pc, sb[0].pc); end
        tick();
        f_valid = 1'b0;
        d_ready = 1'b1;
        #1;
        total++; if (count !== CW'(expCount) || d_pc !== sb[0].pc) begin bad++; $display("[TB] FAIL full_order0: got c=%0d pc=%h required c=%0d pc=%h", count, d_pc, expCount, sb[0].pc); end
        tick();
        total++; if (d_pc !== sb[0].pc || d_instr !== sb[0].instr) begin bad++; $display("[TB] FAIL full_order1: got pc=%h required pc=%h", d_pc, sb[0].pc); end
        tick();
        d_ready = 1'b0;
        total++; if (count !== CW'(expCount)) begin bad++; $display("[TB] FAIL full_empty: got %0d required %0d", count, expCount); end
    endtask

    task automatic test_back_to_back();
        d_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(32'(i * 4), $urandom);
            #1;
            total++; if (d_valid !== 1'b1 || d_pc !== sb[0].pc || d_instr !== sb[0].instr) begin bad++; $display("[TB] FAIL stream_%0d: got v=%b pc=%h i=%h required pc=%h i=%h", i, d_valid, d_pc, d_instr, sb[0].pc, sb[0].instr); end
            total++; if (count !== CW'(1) || expCount != 1) begin bad++; $display("[TB] FAIL stream_count_%0d: got %0d required 1", i, count); end
        end
        f_valid = 1'b0;
        tick();
        d_ready = 1'b0;
        total++; if (count !== CW'(expCount)) begin bad++; $display("[TB] FAIL stream_drain: got %0d required %0d", count, expCount); end
    endtask

    task automatic test_kill();
        d_ready = 1'b0;
        applyStimulus(32'h10, 32'hB000_0010);
        applyStimulus(32'h14, 32'hB000_0014);
        kill    = 1'b1;
        f_pc    = 32'h18;
        d_ready = 1'b1;
        #1;
        total++; if (d_valid !== 1'b0) begin bad++; $display("[TB] FAIL kill_dvalid: got %b required 0", d_valid); end
        tick();
        kill    = 1'b0;
        f_valid = 1'b0;
        d_ready = 1'b0;
        #1;
        total++; if (count !== CW'(expCount) || d_instr !== NOP || f_ready !== 1'b1) begin bad++; $display("[TB] FAIL kill_after: got c=%0d i=%h r=%b required c=%0d i=%h r=1", count, d_instr, f_ready, expCount, NOP); end
        applyStimulus(32'h40, 32'hB000_0040);
        f_valid = 1'b0;
        #1;
        total++; if (d_pc !== sb[0].pc || d_instr !== sb[0].instr) begin bad++; $display("[TB] FAIL kill_push40: got %h required %h", d_pc, sb[0].pc); end
        kill    = 1'b1;
        f_valid = 1'b1;
        f_pc    = 32'h44;
        tick();
        tick();
        kill    = 1'b0;
        f_valid = 1'b0;
        #1;
        total++; if (count !== CW'(expCount) || d_valid !== 1'b0) begin bad++; $display("[TB] FAIL kill_repeat: got c=%0d v=%b required c=%0d v=0", count, d_valid, expCount); end
    endtask

    task automatic test_misalign();
        d_ready = 1'b0;
        applyStimulus(32'h22, 32'hC000_0022);
        applyStimulus(32'h24, 32'hC000_0024);
        f_valid = 1'b0;
        #1;
        total++; if (d_pc !== sb[0].pc || d_misalign !== sb[0].mis) begin bad++; $display("[TB] FAIL mis_22: got pc=%h m=%b required pc=%h m=%b", d_pc, d_misalign, sb[0].pc, sb[0].mis); end
        d_ready = 1'b1;
        tick();
        total++; if (d_pc !== sb[0].pc || d_misalign !== sb[0].mis) begin bad++; $display("[TB] FAIL mis_24: got pc=%h m=%b required pc=%h m=%b", d_pc, d_misalign, sb[0].pc, sb[0].mis); end
        tick();
        d_ready = 1'b0;
        total++; if (d_misalign !== 1'b0 || count !== CW'(expCount)) begin bad++; $display("[TB] FAIL mis_empty: got m=%b c=%0d required m=0 c=%0d", d_misalign, count, expCount); end
    endtask

    task automatic test_async_reset();
        d_ready = 1'b0;
        applyStimulus(32'h60, 32'hD000_0060);
        applyStimulus(32'h64, 32'hD000_0064);
        f_valid = 1'b0;
        #1;
        total++; if (count !== CW'(expCount)) begin bad++; $display("[TB] FAIL arst_pre: got %0d required %0d", count, expCount); end
        #2;
        rst_n = 1'b0;
        sb.delete();
        expCount = 0;
        #1;
        total++; if (count !== '0 || d_valid !== 1'b0 || f_ready !== 1'b1 || d_instr !== NOP) begin bad++; $display("[TB] FAIL arst_now: got c=%0d v=%b r=%b i=%h required c=0 v=0 r=1 i=%h", count, d_valid, f_ready, d_instr, NOP); end
        #1;
        rst_n = 1'b1;
        @(posedge CLK);
        #1;
        applyStimulus(32'h80, 32'hD000_0080);
        f_valid = 1'b0;
        #1;
        total++; if (d_pc !== sb[0].pc || count !== CW'(expCount) || d_valid !== 1'b1) begin bad++; $display("[TB] FAIL arst_after: got pc=%h c=%0d required pc=%h c=%0d", d_pc, count, sb[0].pc, expCount); end
        d_ready = 1'b1;
        tick();
        d_ready = 1'b0;
    endtask

    // Run every scenario in sequence, then print the summary line.
    initial begin
        rst_n   = 1'b0;
        f_valid = 1'b0;
        f_pc    = '0;
        f_instr = '0;
        kill    = 1'b0;
        d_ready = 1'b0;
        test_reset();
        #11;
        rst_n = 1'b1;
        @(posedge CLK);
        #1;
        test_single();
        test_full();
        test_back_to_back();
        test_kill();
        test_misalign();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
